// File: rtl/gate_prober.sv
// Gate prober: sweeps {a,b} over 00,01,10,11, captures the gate's response and classifies it.
// Optional GATE_PROBER_REPEAT_EN runs the sweep twice and flags disagreement between passes.
module gate_prober #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth,
  output logic [2:0] gate_id,
  output logic       valid_id,
  output logic       mismatch
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PROBE    = 2'd1,
    CLASSIFY = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] settle_q;
  logic [1:0] vec_q;
  logic       cls_q;
  logic [3:0] sample_q;
  logic [2:0] id_q;
  logic       vec_end;
  logic       last_vec;
  logic       sweep_end;

  assign vec_end  = (settle_q == SETTLE_LAST);
  assign last_vec = vec_end && (vec_q == 2'd3);

`ifdef GATE_PROBER_REPEAT_EN
  logic       pass_q;
  logic [3:0] pass1_q;
  logic       mm_q;
  logic       mismatch_q;

  assign sweep_end = last_vec && pass_q;
  assign mismatch  = mismatch_q;
`else
  assign sweep_end = last_vec;
  assign mismatch  = 1'b0;
`endif

  function automatic logic [2:0] classify(input logic [3:0] t);
    logic [2:0] id;
    id = 3'd0;
    case (t)
      4'b1000: id = 3'd1;
      4'b1110: id = 3'd2;
      4'b0011: id = 3'd3;
      4'b0111: id = 3'd4;
      4'b0001: id = 3'd5;
      4'b0110: id = 3'd6;
      4'b1001: id = 3'd7;
      default: id = 3'd0;
    endcase
    return id;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // CLASSIFY takes two cycles: one to decode into id_q, one to commit on the edge entering DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = PROBE;
      PROBE:    if (sweep_end) state_d = CLASSIFY;
      CLASSIFY: if (cls_q) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign a_out = (state_q == PROBE) && vec_q[1];
  assign b_out = (state_q == PROBE) && vec_q[0];
  assign busy  = (state_q == PROBE) || (state_q == CLASSIFY);
  assign done  = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q   <= 4'd0;
      vec_q      <= 2'd0;
      cls_q      <= 1'b0;
      sample_q   <= 4'd0;
      id_q       <= 3'd0;
      truth      <= 4'd0;
      gate_id    <= 3'd0;
      valid_id   <= 1'b0;
`ifdef GATE_PROBER_REPEAT_EN
      pass_q     <= 1'b0;
      pass1_q    <= 4'd0;
      mm_q       <= 1'b0;
      mismatch_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          settle_q <= 4'd0;
          vec_q    <= 2'd0;
          cls_q    <= 1'b0;
`ifdef GATE_PROBER_REPEAT_EN
          pass_q   <= 1'b0;
`endif
        end
        PROBE: begin
          if (vec_end) begin
            settle_q        <= 4'd0;
            vec_q           <= vec_q + 2'd1;
            sample_q[vec_q] <= y_in;
`ifdef GATE_PROBER_REPEAT_EN
            if (last_vec && !pass_q) begin
              pass_q  <= 1'b1;
              pass1_q <= {y_in, sample_q[2:0]};
            end
`endif
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        CLASSIFY: begin
          cls_q <= 1'b1;
          if (!cls_q) begin
`ifdef GATE_PROBER_REPEAT_EN
            mm_q <= (pass1_q != sample_q);
            id_q <= (pass1_q != sample_q) ? 3'd0 : classify(sample_q);
`else
            id_q <= classify(sample_q);
`endif
          end else begin
            truth      <= sample_q;
            gate_id    <= id_q;
            valid_id   <= (id_q != 3'd0);
`ifdef GATE_PROBER_REPEAT_EN
            mismatch_q <= mm_q;
`endif
          end
        end
        DONE: begin
          cls_q <= 1'b0;
        end
        default: begin
          cls_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_prober.sv
// Scoreboard bench for gate_prober: directed gate models, expected results queued at launch
// and checked by an independent monitor whenever done pulses.
module tb_gate_prober;

  localparam int S  = 2;
`ifdef GATE_PROBER_REPEAT_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int LAT  = PASSES * 4 * (S + 1) + 2;
  localparam int LAT0 = PASSES * 4 + 2;
  localparam int W    = 10;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       y_in;
  logic       a_out;
  logic       b_out;
  logic       busy;
  logic       done;
  logic [3:0] truth;
  logic [2:0] gate_id;
  logic       valid_id;
  logic       mismatch;

  logic       start0;
  logic       y0;
  logic       a0, b0, busy0, done0, valid0, mm0;
  logic [3:0] truth0;
  logic [2:0] id0;

  int         mode;
  logic       pass_sel;
  int         cyc;
  int         checks;
  int         fails;

  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  logic [3:0]   tt_tab[1:8];
  logic [2:0]   id_tab[1:8];

  gate_prober #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_in),
    .a_out(a_out), .b_out(b_out), .busy(busy), .done(done),
    .truth(truth), .gate_id(gate_id), .valid_id(valid_id), .mismatch(mismatch)
  );

  gate_prober #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .y_in(y0),
    .a_out(a0), .b_out(b0), .busy(busy0), .done(done0),
    .truth(truth0), .gate_id(id0), .valid_id(valid0), .mismatch(mm0)
  );

  function automatic logic model(input int m, input logic a, input logic b, input logic p);
    logic y;
    y = 1'b0;
    case (m)
      1: y = a & b;
      2: y = a | b;
      3: y = ~a;
      4: y = ~(a & b);
      5: y = ~(a | b);
      6: y = a ^ b;
      7: y = ~(a ^ b);
      8: y = 1'b1;
      9: y = p ? ~(a ^ b) : (a ^ b);
      default: y = 1'b0;
    endcase
    return y;
  endfunction

  always_comb y_in = model(mode, a_out, b_out, pass_sel);
  always_comb y0   = a0 | b0;

  // Clock and cycle counter: cyc equals k after rising edge k.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest queued expectation, at the expected edge.
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    int           ecyc;
    if (rst_n && done) begin
      got = {busy, truth, gate_id, valid_id, mismatch};
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: cycle %0d got %b with nothing expected", cyc, got);
      end else begin
        exp  = exp_q.pop_front();
        ecyc = cyc_q.pop_front();
        if (got !== exp) begin
          fails++;
          $display("FAIL result: got {busy,truth,id,valid,mm}=%b required %b", got, exp);
        end
        checks++;
        if (cyc != ecyc) begin
          fails++;
          $display("FAIL done_edge: got edge %0d required edge %0d", cyc, ecyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic expect_result(input int launch, input logic [3:0] t, input logic [2:0] id,
                               input logic mm);
    exp_q.push_back({1'b0, t, id, (id != 3'd0), mm});
    cyc_q.push_back(launch + LAT);
  endtask

  // Issues a one-cycle start pulse; on return cyc equals launch edge k.
  task automatic probe(input int m, input logic [3:0] t, input logic [2:0] id, input logic mm);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    expect_result(cyc + 1, t, id, mm);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (exp_q.size() > 0 && i < 400) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL timeout: %0d expected done pulses never arrived", exp_q.size());
      exp_q.delete();
      cyc_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int k0;
    logic seen;
    checks   = 0;
    fails    = 0;
    mode     = 0;
    pass_sel = 1'b0;
    start    = 1'b0;
    start0   = 1'b0;
    rst_n    = 1'b0;
    tt_tab = '{4'b1000, 4'b1110, 4'b0011, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b1111};
    id_tab = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", {a_out, b_out, busy, done, truth, gate_id, valid_id, mismatch}, 0);

    // All seven gates plus y stuck high.
    for (int m = 1; m <= 8; m++) begin
      probe(m, tt_tab[m], id_tab[m], 1'b0);
      drain();
    end

    // Second start while busy is ignored; results hold during a new probe.
    probe(1, 4'b1000, 3'd1, 1'b0);
    repeat (4) @(negedge clk);
    check("busy_mid_probe", busy, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (LAT + 4) @(negedge clk);
    probe(4, 4'b0111, 3'd4, 1'b0);
    repeat (8) @(negedge clk);
    check("hold_during_probe", {truth, gate_id, valid_id}, {4'b1000, 3'd1, 1'b1});
    drain();

    // Reset during vector 2 aborts with no done, then an XOR probe.
    @(negedge clk);
    mode  = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2 * (S + 1)) @(negedge clk);
    check("vector2_drive", {a_out, b_out}, 2'b10);
    rst_n = 1'b0;
    #1;
    check("reset_abort", {a_out, b_out, busy, done, truth, gate_id, valid_id, mismatch}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    probe(6, 4'b0110, 3'd6, 1'b0);
    drain();

    // start held high: next launch two edges after done (DONE, then one IDLE cycle).
    @(negedge clk);
    mode  = 5;
    start = 1'b1;
    expect_result(cyc + 1, 4'b0001, 3'd5, 1'b0);
    expect_result(cyc + 1 + LAT + 2, 4'b0001, 3'd5, 1'b0);
    repeat (LAT + 4) @(negedge clk);
    start = 1'b0;
    drain();

`ifdef GATE_PROBER_REPEAT_EN
    // XOR in pass 1, XNOR in pass 2.
    pass_sel = 1'b0;
    probe(9, 4'b1001, 3'd0, 1'b1);
    repeat (4 * (S + 1)) @(negedge clk);
    pass_sel = 1'b1;
    drain();
    pass_sel = 1'b0;
`endif

    // SETTLE_CYCLES=0 instance with an OR gate.
    @(negedge clk);
    start0 = 1'b1;
    k0     = cyc + 1;
    @(negedge clk);
    start0 = 1'b0;
    seen   = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done0) begin
        seen = 1'b1;
        check("s0_done_edge", cyc, k0 + LAT0);
        check("s0_result", {busy0, truth0, id0, valid0}, {1'b0, 4'b1110, 3'd2, 1'b1});
      end else begin
        @(negedge clk);
      end
    end
    check("s0_done_seen", seen, 1'b1);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
